usb_crc_engine: RTL and testbench

- Parametrised serial CRC engine for the USB endpoint; one instance type serves CRC5 (tokens) and CRC16 (data packets).
- Generate mode: accumulates the outgoing bitstream, then serialises the inverted CRC to the TX encoder through a per-bit handshake.
- Check mode: accumulates the received bitstream including its CRC field and compares the final register to the residue constant.
- Sits between the bit-stuff/unstuff stage and the packet FSMs.

---
 rtl/usb_crc_pkg.sv | 19 +
 rtl/usb_crc_lfsr.sv | 19 +
 rtl/usb_crc_engine.sv | 118 +++++++++++
 tb/tb_usb_crc_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_crc_pkg.sv
// usb_crc_pkg: shared types and constants for the USB CRC engine.
//   state_t        - engine FSM states
//   CRC5_*/CRC16_* - generator polynomials (x^W term dropped) and the
//                    good-packet residues seen after clocking in data+CRC.
package usb_crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SHIFT = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [4:0]  CRC5_POLY     = 5'b00101;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

endpackage

// File: rtl/usb_crc_lfsr.sv
// usb_crc_lfsr: combinational single-bit step of a serial CRC register.
//   crc      in  current register
//   bit_in   in  next bit in transmission order
//   crc_next out register after absorbing bit_in
module usb_crc_lfsr #(
  parameter int              CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY = 5'b00101
) (
  input  logic [CRC_W-1:0] crc,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_next
);

  logic fb;

  assign fb       = bit_in ^ crc[CRC_W-1];
  assign crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/usb_crc_engine.sv
// usb_crc_engine: serial CRC generator/checker for the USB endpoint.
//   clk, rst            clock, async active-high reset
//   start, mode         load INIT and enter ACCUM; mode 0=generate, 1=check
//   bit_in, bit_valid   destuffed serial data
//   finish              end of data (gen) / end of data+CRC (check)
//   shift_en            downstream consumes bit_out this cycle
//   bit_out(_valid)     serialised inverted CRC, MSB first, in SHIFT
//   busy, done          activity flag, one-cycle end-of-operation pulse
//   crc_ok              check result, valid from done until next start
//   crc_value           live CRC register
//   bit_count           saturating count of bits accumulated since start
module usb_crc_engine
  import usb_crc_pkg::*;
#(
  parameter int               CRC_W   = 5,
  parameter logic [CRC_W-1:0] POLY    = CRC5_POLY,
  parameter logic [CRC_W-1:0] INIT    = '1,
  parameter logic [CRC_W-1:0] RESIDUE = CRC5_RESIDUE,
  parameter int               CNT_W   = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             finish,
  input  logic             shift_en,
  output logic             bit_out,
  output logic             bit_out_valid,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic [CRC_W-1:0] crc_value,
  output logic [CNT_W-1:0] bit_count
);

  localparam int IDX_W = $clog2(CRC_W + 1);

  state_t           state, state_d;
  logic [CRC_W-1:0] crc, crc_step, crc_eff, out_sr;
  logic [IDX_W-1:0] idx;
  logic             mode_q, last_shift;

  usb_crc_lfsr #(.CRC_W(CRC_W), .POLY(POLY)) u_lfsr (
    .crc      (crc),
    .bit_in   (bit_in),
    .crc_next (crc_step)
  );

  // A bit arriving together with finish is folded in before finishing.
  assign crc_eff    = bit_valid ? crc_step : crc;
  assign last_shift = (idx == IDX_W'(CRC_W - 1));

  always_comb begin
    state_d = state;
    case (state)
      ACCUM:   if (finish) state_d = mode_q ? CHECK : SHIFT;
      SHIFT:   if (shift_en && last_shift) state_d = IDLE;
      CHECK:   state_d = IDLE;
      default: state_d = state;
    endcase
    // start aborts anything in flight, including a same-cycle finish.
    if (start) state_d = ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      crc       <= INIT;
      out_sr    <= '0;
      idx       <= '0;
      mode_q    <= 1'b0;
      bit_count <= '0;
      crc_ok    <= 1'b0;
    end else begin
      state <= state_d;
      if (start) begin
        crc       <= INIT;
        out_sr    <= '0;
        idx       <= '0;
        mode_q    <= mode;
        bit_count <= '0;
        crc_ok    <= 1'b0;
      end else begin
        case (state)
          ACCUM: begin
            if (bit_valid) begin
              crc <= crc_step;
              if (bit_count != '1) bit_count <= bit_count + 1'b1;
            end
            if (finish && !mode_q) begin
              out_sr <= ~crc_eff;
              idx    <= '0;
            end
            // Result registered at finish so it is already valid with done.
            if (finish && mode_q) crc_ok <= (crc_eff == RESIDUE);
          end
          SHIFT: begin
            if (shift_en) begin
              out_sr <= {out_sr[CRC_W-2:0], 1'b0};
              idx    <= idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bit_out_valid = (state == SHIFT);
  assign bit_out       = bit_out_valid & out_sr[CRC_W-1];
  assign busy          = (state != IDLE);
  assign done          = !start && ((state == CHECK) ||
                         ((state == SHIFT) && shift_en && last_shift));
  assign crc_value     = crc;

endmodule

// File: tb/tb_usb_crc_engine.sv
module tb_usb_crc_engine;
  import usb_crc_pkg::*;

  logic clk = 1'b0;
  logic rst, start, mode, bit_in, bit_valid, finish, shift_en;

  logic        c5_bo, c5_bov, c5_busy, c5_done, c5_ok;
  logic [4:0]  c5_crc;
  logic [13:0] c5_cnt;
  logic        s_bo, s_bov, s_busy, s_done, s_ok;
  logic [4:0]  s_crc;
  logic [3:0]  s_cnt;
  logic        w_bo, w_bov, w_busy, w_done, w_ok;
  logic [15:0] w_crc;
  logic [13:0] w_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_crc_engine u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .bit_in(bit_in),
    .bit_valid(bit_valid), .finish(finish), .shift_en(shift_en),
    .bit_out(c5_bo), .bit_out_valid(c5_bov), .busy(c5_busy), .done(c5_done),
    .crc_ok(c5_ok), .crc_value(c5_crc), .bit_count(c5_cnt)
  );

  usb_crc_engine #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .bit_in(bit_in),
    .bit_valid(bit_valid), .finish(finish), .shift_en(shift_en),
    .bit_out(s_bo), .bit_out_valid(s_bov), .busy(s_busy), .done(s_done),
    .crc_ok(s_ok), .crc_value(s_crc), .bit_count(s_cnt)
  );

  usb_crc_engine #(.CRC_W(16), .POLY(CRC16_POLY), .RESIDUE(CRC16_RESIDUE)) u_16 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .bit_in(bit_in),
    .bit_valid(bit_valid), .finish(finish), .shift_en(shift_en),
    .bit_out(w_bo), .bit_out_valid(w_bov), .busy(w_busy), .done(w_done),
    .crc_ok(w_ok), .crc_value(w_crc), .bit_count(w_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m);
    start = 1'b1; mode = m;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic b);
    bit_valid = 1'b1; bit_in = b;
    cyc();
    bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  // CRC5 over 11 zero bits: register 10111, serial output ~10111 = 0,1,0,0,0.
  task automatic gen_crc5_zero(input bit bit_with_finish, input string tag);
    logic [4:0] exp_out;
    exp_out = 5'b01000;
    shift_en = 1'b1;
    do_start(1'b0);
    for (int i = 0; i < 10; i++) send(1'b0);
    if (bit_with_finish) begin
      bit_valid = 1'b1; bit_in = 1'b0; finish = 1'b1;
      cyc();
      bit_valid = 1'b0; finish = 1'b0;
    end else begin
      send(1'b0);
      finish = 1'b1;
      cyc();
      finish = 1'b0;
    end
    chk({tag, "_crc"}, 32'(c5_crc), 32'h17);
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_bov"}, 32'(c5_bov), 32'd1);
      chk({tag, "_bo"}, 32'(c5_bo), 32'(exp_out[4-i]));
      chk({tag, "_done"}, 32'(c5_done), (i == 4) ? 32'd1 : 32'd0);
      cyc();
    end
    shift_en = 1'b0;
    chk({tag, "_busy_end"}, 32'(c5_busy), 32'd0);
    chk({tag, "_done_end"}, 32'(c5_done), 32'd0);
    chk({tag, "_cnt"}, 32'(c5_cnt), 32'd11);
  endtask

  initial begin
    logic [15:0] pkt;
    rst = 1'b1; start = 1'b0; mode = 1'b0; bit_in = 1'b0;
    bit_valid = 1'b0; finish = 1'b0; shift_en = 1'b0;
    #12;
    chk("rst_busy", 32'(c5_busy), 32'd0);
    chk("rst_done", 32'(c5_done), 32'd0);
    chk("rst_ok", 32'(c5_ok), 32'd0);
    chk("rst_bov", 32'(c5_bov), 32'd0);
    chk("rst_bo", 32'(c5_bo), 32'd0);
    chk("rst_crc", 32'(c5_crc), 32'h1f);
    chk("rst_cnt", 32'(c5_cnt), 32'd0);
    rst = 1'b0;
    cyc();

    // bits outside ACCUM are ignored
    send(1'b1);
    chk("idle_ignore_crc", 32'(c5_crc), 32'h1f);

    gen_crc5_zero(1'b0, "gen5");
    gen_crc5_zero(1'b1, "gen5_vf");

    // CRC5 check: 11 zeros followed by CRC 01000 leaves the residue.
    pkt = 16'b00000000000_01000;
    do_start(1'b1);
    for (int i = 0; i < 16; i++) send(pkt[15-i]);
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    chk("chk_done", 32'(c5_done), 32'd1);
    chk("chk_ok", 32'(c5_ok), 32'd1);
    chk("chk_crc", 32'(c5_crc), 32'h0c);
    cyc();
    chk("chk_done_clr", 32'(c5_done), 32'd0);
    chk("chk_ok_hold", 32'(c5_ok), 32'd1);
    chk("chk_busy", 32'(c5_busy), 32'd0);

    // single-bit error must be caught
    pkt = pkt ^ 16'h1000;
    do_start(1'b1);
    chk("chk_ok_clr_on_start", 32'(c5_ok), 32'd0);
    for (int i = 0; i < 16; i++) send(pkt[15-i]);
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    chk("chkbad_done", 32'(c5_done), 32'd1);
    chk("chkbad_ok", 32'(c5_ok), 32'd0);
    cyc();

    // CRC16 zero-length packet, shift_en held high: 16 zeros (~INIT).
    do_start(1'b0);
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    shift_en = 1'b1;
    #1;
    chk("z16_crc", 32'(w_crc), 32'hffff);
    for (int i = 0; i < 16; i++) begin
      chk("z16_bov", 32'(w_bov), 32'd1);
      chk("z16_bo", 32'(w_bo), 32'd0);
      chk("z16_done", 32'(w_done), (i == 15) ? 32'd1 : 32'd0);
      cyc();
    end
    shift_en = 1'b0;
    chk("z16_busy", 32'(w_busy), 32'd0);
    chk("z16_cnt", 32'(w_cnt), 32'd0);

    // CRC16 zero-length with shift_en toggling: 32 cycles for 16 shifts.
    do_start(1'b0);
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    for (int k = 0; k < 32; k++) begin
      shift_en = k[0];
      #1;
      chk("t16_bov", 32'(w_bov), 32'd1);
      chk("t16_bo", 32'(w_bo), 32'd0);
      chk("t16_done", 32'(w_done), (k == 31) ? 32'd1 : 32'd0);
      cyc();
    end
    shift_en = 1'b0;
    chk("t16_busy", 32'(w_busy), 32'd0);

    // start on the final shift of a CRC5 gen aborts it without done.
    do_start(1'b0);
    for (int i = 0; i < 3; i++) send(1'b1);
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    shift_en = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    start = 1'b1;
    #1;
    chk("abort_bov", 32'(c5_bov), 32'd1);
    chk("abort_done", 32'(c5_done), 32'd0);
    cyc();
    start = 1'b0; shift_en = 1'b0;
    chk("abort_busy", 32'(c5_busy), 32'd1);
    chk("abort_bov_after", 32'(c5_bov), 32'd0);
    chk("abort_crc", 32'(c5_crc), 32'h1f);
    chk("abort_cnt", 32'(c5_cnt), 32'd0);

    // async reset mid-ACCUM
    for (int i = 0; i < 6; i++) send(1'b1);
    chk("pre_rst_cnt", 32'(c5_cnt), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(c5_busy), 32'd0);
    chk("mrst_crc", 32'(c5_crc), 32'h1f);
    chk("mrst_cnt", 32'(c5_cnt), 32'd0);
    chk("mrst_bov", 32'(c5_bov), 32'd0);
    chk("mrst_ok", 32'(c5_ok), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    gen_crc5_zero(1'b0, "gen5_post_rst");

    // 20 zero bits: CNT_W=4 saturates at 15, register reaches 10000.
    do_start(1'b1);
    for (int i = 0; i < 20; i++) send(1'b0);
    chk("sat_cnt", 32'(s_cnt), 32'd15);
    chk("sat_crc", 32'(s_crc), 32'h10);
    chk("wide_cnt", 32'(c5_cnt), 32'd20);
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    chk("sat_done", 32'(s_done), 32'd1);
    chk("sat_ok", 32'(s_ok), 32'd0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
